// File: rtl/flp_imult.sv
// Pipelined unsigned WIDTH x WIDTH multiplier: partial products, 3:2 CSA tree, final carry-propagate add.
// Optional input register stage when FLP_IMULT_INREG_EN is defined (latency 3 instead of 2).
module flp_imult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_vld,
    input  logic [WIDTH-1:0]     i_mlpr,
    input  logic [WIDTH-1:0]     i_mlpd,
    output logic                 o_vld,
    output logic [2*WIDTH-1:0]   o_prod
);

    localparam int PW = 2 * WIDTH;

    // Number of 3:2 reduction levels needed to bring WIDTH rows down to two.
    function automatic int calc_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l = l + 1;
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);

    logic [WIDTH-1:0] mlpr_s;
    logic [WIDTH-1:0] mlpd_s;
    logic             vld_s;

`ifdef FLP_IMULT_INREG_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mlpr_s <= '0;
            mlpd_s <= '0;
            vld_s  <= 1'b0;
        end else begin
            mlpr_s <= i_mlpr;
            mlpd_s <= i_mlpd;
            vld_s  <= i_vld;
        end
    end
`else
    always_comb begin
        mlpr_s = i_mlpr;
        mlpd_s = i_mlpd;
        vld_s  = i_vld;
    end
`endif

    logic [PW-1:0] tree [0:LEVELS][0:WIDTH-1];
    logic [PW-1:0] csa_sum;
    logic [PW-1:0] csa_carry;

    // Each level groups rows in threes; leftover rows (n mod 3) pass straight through.
    always_comb begin
        int n;
        for (int l = 0; l <= LEVELS; l++) begin
            for (int k = 0; k < WIDTH; k++) begin
                tree[l][k] = '0;
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            tree[0][k] = {{WIDTH{1'b0}}, mlpd_s & {WIDTH{mlpr_s[k]}}} << k;
        end
        n = WIDTH;
        for (int l = 0; l < LEVELS; l++) begin
            for (int g = 0; g < WIDTH / 3; g++) begin
                if (g < n / 3) begin
                    tree[l+1][2*g]   = tree[l][3*g] ^ tree[l][3*g+1] ^ tree[l][3*g+2];
                    tree[l+1][2*g+1] = ((tree[l][3*g] & tree[l][3*g+1]) |
                                        (tree[l][3*g] & tree[l][3*g+2]) |
                                        (tree[l][3*g+1] & tree[l][3*g+2])) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < n % 3) begin
                    tree[l+1][2*(n/3)+r] = tree[l][3*(n/3)+r];
                end
            end
            n = 2 * (n / 3) + (n % 3);
        end
        csa_sum   = tree[LEVELS][0];
        csa_carry = tree[LEVELS][1];
    end

    logic [PW-1:0] sum_q;
    logic [PW-1:0] carry_q;
    logic          vld_a;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sum_q   <= '0;
            carry_q <= '0;
            vld_a   <= 1'b0;
        end else begin
            sum_q   <= csa_sum;
            carry_q <= csa_carry;
            vld_a   <= vld_s;
        end
    end

    // Any carry beyond PW bits is zero by construction, so the PW-bit add is exact.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_prod <= '0;
            o_vld  <= 1'b0;
        end else begin
            o_prod <= sum_q + carry_q;
            o_vld  <= vld_a;
        end
    end

endmodule

// File: tb/tb_flp_imult.sv
// Scoreboard bench for flp_imult: expected products are queued with their due cycle and
// a negedge monitor compares them against o_vld/o_prod.
module tb_flp_imult;

    parameter int WIDTH = 32;
`ifdef FLP_IMULT_INREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int PW = 2 * WIDTH;

    logic             clk;
    logic             nrst;
    logic             i_vld;
    logic [WIDTH-1:0] i_mlpr;
    logic [WIDTH-1:0] i_mlpd;
    logic             o_vld;
    logic [PW-1:0]    o_prod;

    flp_imult #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .i_vld  (i_vld),
        .i_mlpr (i_mlpr),
        .i_mlpd (i_mlpd),
        .o_vld  (o_vld),
        .o_prod (o_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [PW-1:0] prod;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain arithmetic on zero-extended operands.
    function automatic logic [PW-1:0] refmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [PW-1:0] wa;
        logic [PW-1:0] wb;
        wa = PW'(a);
        wb = PW'(b);
        return wa * wb;
    endfunction

    task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        @(negedge clk);
        i_vld  = vld;
        i_mlpr = a;
        i_mlpd = b;
        if (vld && nrst) begin
            e.due  = cyc + LAT;
            e.prod = refmul(a, b);
            sb.push_back(e);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (!nrst) begin
            check("reset_vld", 128'(o_vld), 128'(1'b0));
            check("reset_prod", 128'(o_prod), 128'(0));
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("vld_at_latency", 128'(o_vld), 128'(1'b1));
            check("prod", 128'(o_prod), 128'(e.prod));
        end else begin
            check("no_spurious_vld", 128'(o_vld), 128'(1'b0));
        end
    endtask

    always @(negedge clk) checkOutput();

    logic [WIDTH-1:0] dir_a [8];
    logic [WIDTH-1:0] dir_b [8];
    logic [63:0]      r1;
    logic [63:0]      r2;
    logic [3:0]       gap_pat;

    initial begin
        nrst   = 1'b0;
        i_vld  = 1'b0;
        i_mlpr = '0;
        i_mlpd = '0;
        #1;
        check("init_vld", 128'(o_vld), 128'(1'b0));
        check("init_prod", 128'(o_prod), 128'(0));
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        dir_a[0] = WIDTH'(64'h0);          dir_b[0] = WIDTH'(64'h0);
        dir_a[1] = WIDTH'(64'h1);          dir_b[1] = WIDTH'(64'h0);
        dir_a[2] = WIDTH'(64'h0);          dir_b[2] = WIDTH'(64'h1);
        dir_a[3] = WIDTH'(64'h1000);       dir_b[3] = WIDTH'(64'h1000);
        dir_a[4] = WIDTH'(64'h00011010);   dir_b[4] = WIDTH'(64'h00101001);
        dir_a[5] = WIDTH'(64'h2);          dir_b[5] = WIDTH'(64'h3);
        dir_a[6] = '1;                     dir_b[6] = '1;
        dir_a[7] = '1;                     dir_b[7] = WIDTH'(64'h1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, dir_a[i], dir_b[i]);
        gap_pat = 4'b1101;
        for (int i = 0; i < 8; i++) applyStimulus(gap_pat[i % 4], dir_a[i], dir_b[i]);
        repeat (LAT + 2) applyStimulus(1'b0, '0, '0);

        // Reset while valid data is streaming: in-flight products are dropped.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, dir_a[6], dir_b[6]);
        #2;
        nrst = 1'b0;
        sb.delete();
        #1;
        check("reset_imm_vld", 128'(o_vld), 128'(1'b0));
        check("reset_imm_prod", 128'(o_prod), 128'(0));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, dir_a[4], dir_b[4]);
        @(negedge clk);
        i_vld = 1'b0;
        #2;
        nrst = 1'b1;
        repeat (LAT + 2) applyStimulus(1'b0, dir_a[6], dir_b[6]);

        for (int i = 0; i < 4000; i++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            applyStimulus(($urandom_range(0, 7) != 0), r1[WIDTH-1:0], r2[WIDTH-1:0]);
        end
        repeat (LAT + 2) applyStimulus(1'b0, '0, '0);

        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
